// File: rtl/lab1_response_checker.sv
// Response checker for the Lab1 exhaustive ABCD sweep: compares every DUT F output against a
// golden truth table, checks that vectors arrive 0..15 in order, and reports one verdict.
module lab1_response_checker #(
  parameter int unsigned NUM_F     = 3,
  parameter logic [15:0] EXP_TABLE = 16'h0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [3:0]       in_vec_i,
  input  logic [NUM_F-1:0] in_f_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [4:0]       err_count_o,
  output logic [3:0]       first_fail_vec_o,
  output logic [NUM_F-1:0] first_fail_mask_o,
  output logic             seq_err_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [3:0]       exp_idx_q;
  logic [4:0]       err_count_q;
  logic [3:0]       ff_vec_q;
  logic [NUM_F-1:0] ff_mask_q;
  logic             seq_err_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic             ord_bad;
  logic [NUM_F-1:0] mask;
  logic             fail;
  logic [4:0]       err_count_inc;
  logic             pass_last;

  always_comb begin
    ord_bad       = (in_vec_i != exp_idx_q);
    mask          = in_f_i ^ {NUM_F{EXP_TABLE[in_vec_i]}};
    fail          = ord_bad || (mask != '0);
    err_count_inc = (err_count_q == 5'd16) ? err_count_q : err_count_q + 5'd1;
    // Verdict for the sweep as it closes, including the final sample itself.
    pass_last     = !fail && (err_count_q == 5'd0) && !seq_err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      exp_idx_q   <= 4'd0;
      err_count_q <= 5'd0;
      ff_vec_q    <= 4'd0;
      ff_mask_q   <= '0;
      seq_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          // A sample coinciding with start is dropped; the sweep begins on the next sample.
          if (start_i) begin
            state_q     <= StRun;
            exp_idx_q   <= 4'd0;
            err_count_q <= 5'd0;
            ff_vec_q    <= 4'd0;
            ff_mask_q   <= '0;
            seq_err_q   <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        StRun: begin
          if (in_valid_i) begin
            exp_idx_q <= exp_idx_q + 4'd1;
            if (fail) begin
              err_count_q <= err_count_inc;
              if (err_count_q == 5'd0) begin
                ff_vec_q  <= in_vec_i;
                ff_mask_q <= mask;
              end
            end
            if (ord_bad) begin
              seq_err_q <= 1'b1;
            end
            if (exp_idx_q == 4'd15) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= pass_last;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign err_count_o       = err_count_q;
  assign first_fail_vec_o  = ff_vec_q;
  assign first_fail_mask_o = ff_mask_q;
  assign seq_err_o         = seq_err_q;

endmodule

// File: tb/tb_lab1_response_checker.sv
// Directed bench for lab1_response_checker: table of whole-sweep scenarios plus hand-written
// sequences for gaps/saturation, reset mid-sweep and start colliding with a sample.
module tb_lab1_response_checker;

  localparam int unsigned NF  = 3;
  localparam logic [15:0] EXP = 16'hA5C3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    in_vec = 4'd0;
  logic [NF-1:0] in_f = '0;
  logic          busy, done, pass, seq_err;
  logic [4:0]    err_count;
  logic [3:0]    ff_vec;
  logic [NF-1:0] ff_mask;

  logic [15:0] exp_tab = EXP;
  int n_vec  = 0;
  int n_fail = 0;

  lab1_response_checker #(
    .NUM_F     (NF),
    .EXP_TABLE (EXP)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .in_valid_i        (in_valid),
    .in_vec_i          (in_vec),
    .in_f_i            (in_f),
    .busy_o            (busy),
    .done_o            (done),
    .pass_o            (pass),
    .err_count_o       (err_count),
    .first_fail_vec_o  (ff_vec),
    .first_fail_mask_o (ff_mask),
    .seq_err_o         (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         bad_a;
    logic [2:0] m_a;
    int         bad_b;
    logic [2:0] m_b;
    logic [3:0] last_vec;
    logic [4:0] e_err;
    logic [3:0] e_ffv;
    logic [2:0] e_ffm;
    logic       e_seq;
    logic       e_pass;
  } row_t;

  row_t rows[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] good_f(input logic [3:0] v);
    return {3{exp_tab[v]}};
  endfunction

  // Optional start pulse, then 16 samples with per-sample F corruption and random idle gaps.
  task automatic run_sweep(input bit do_start, input int bad_a, input logic [2:0] m_a,
                           input int bad_b, input logic [2:0] m_b, input logic [2:0] m_all,
                           input logic [3:0] last_vec, input int gap_max);
    logic [3:0] v;
    logic [2:0] f;
    if (do_start) begin
      start = 1'b1;
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
    end
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        tick();
        chk("done_during_gap", done, 0);
      end
      v = (k == 15) ? last_vec : 4'(k);
      f = good_f(v) ^ m_all;
      if (k == bad_a) f = f ^ m_a;
      if (k == bad_b) f = f ^ m_b;
      in_vec = v;
      in_f = f;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (k < 15) chk("done_before_last", done, 0);
    end
  endtask

  task automatic chk_result(input logic [4:0] e_err, input logic [3:0] e_ffv,
                            input logic [2:0] e_ffm, input logic e_seq, input logic e_pass);
    chk("done", done, 1);
    chk("busy", busy, 0);
    chk("err_count", err_count, e_err);
    chk("first_fail_vec", ff_vec, e_ffv);
    chk("first_fail_mask", ff_mask, e_ffm);
    chk("seq_err", seq_err, e_seq);
    chk("pass", pass, e_pass);
  endtask

  initial begin
    rows[0] = '{-1, 3'b000, -1, 3'b000, 4'd15, 5'd0, 4'd0, 3'b000, 1'b0, 1'b1};
    rows[1] = '{ 6, 3'b010,  9, 3'b010, 4'd15, 5'd2, 4'd6, 3'b010, 1'b0, 1'b0};
    rows[2] = '{-1, 3'b000, -1, 3'b000, 4'd7,  5'd1, 4'd7, 3'b000, 1'b1, 1'b0};
    rows[3] = '{ 0, 3'b001, 15, 3'b100, 4'd15, 5'd2, 4'd0, 3'b001, 1'b0, 1'b0};
    rows[4] = '{15, 3'b100, -1, 3'b000, 4'd3,  5'd1, 4'd3, 3'b100, 1'b1, 1'b0};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ffv", ff_vec, 0);
    chk("rst_ffm", ff_mask, 0);
    chk("rst_seq", seq_err, 0);

    // Samples in IDLE are ignored.
    in_valid = 1'b1;
    in_vec = 4'd0;
    in_f = ~good_f(4'd0);
    tick();
    in_valid = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_err", err_count, 0);

    foreach (rows[i]) begin
      run_sweep(1'b1, rows[i].bad_a, rows[i].m_a, rows[i].bad_b, rows[i].m_b, 3'b000,
                rows[i].last_vec, 0);
      chk_result(rows[i].e_err, rows[i].e_ffv, rows[i].e_ffm, rows[i].e_seq, rows[i].e_pass);
    end

    // Every sample wrong, with idle gaps: count reaches exactly 16.
    run_sweep(1'b1, -1, 3'b000, -1, 3'b000, 3'b111, 4'd15, 5);
    chk_result(5'd16, 4'd0, 3'b111, 1'b0, 1'b0);

    // DONE ignores further samples.
    in_valid = 1'b1;
    in_vec = 4'd0;
    in_f = good_f(4'd0);
    tick();
    in_valid = 1'b0;
    chk("done_hold_err", err_count, 16);
    chk("done_hold", done, 1);

    // Reset part-way through a failing sweep.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_vec = 4'(k);
      in_f = ~good_f(4'(k));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("mid_err", err_count, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_ffm", ff_mask, 0);
    run_sweep(1'b1, -1, 3'b000, -1, 3'b000, 3'b000, 4'd15, 2);
    chk_result(5'd0, 4'd0, 3'b000, 1'b0, 1'b1);

    // start with a wrong sample in DONE: start wins, sample dropped, index stays at 0.
    start = 1'b1;
    in_valid = 1'b1;
    in_vec = 4'd0;
    in_f = ~good_f(4'd0);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    chk("restart_pass", pass, 0);
    chk("restart_err", err_count, 0);
    run_sweep(1'b0, -1, 3'b000, -1, 3'b000, 3'b000, 4'd15, 1);
    chk_result(5'd0, 4'd0, 3'b000, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lab1_response_checker.md
Name: lab1_response_checker

Overview:
- Synthesizable response-side companion to the Lab1 exhaustive stimulus sweep.
- The stimulus side applies the 16 ABCD vectors in order, one per step.
- This block takes each applied vector plus the F outputs of all DUT implementations, compares them against a golden truth table, enforces the 0..15 ordering, and reports pass/fail with error count and first-failure capture.
- It replaces manual waveform inspection with a single verdict.

Parameters:
- NUM_F, 3, number of DUT implementations whose F outputs are checked in parallel (1..8).
- EXP_TABLE, 16'h0000, golden F per vector; bit k = expected F for ABCD = k (A = MSB).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a sweep check
- in_valid  input  1  in_vec/in_f hold one sample this cycle
- in_vec  input  4  applied vector {A,B,C,D}
- in_f  input  NUM_F  DUT outputs; bit i = F(i+1)
- busy  output  1  high while in RUN
- done  output  1  high while in DONE
- pass  output  1  verdict, valid only while done=1
- err_count  output  5  number of failing samples, 0..16
- first_fail_vec  output  4  in_vec of the first failing sample
- first_fail_mask  output  NUM_F  per-DUT mismatch bits of the first failing sample
- seq_err  output  1  sticky; a sample arrived out of order

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything. After reset, FSM=IDLE and every output and internal register is 0, including exp_idx.
- FSM states are IDLE, RUN and DONE. Exactly one transition can occur per clock.
- IDLE:
  - in_valid is ignored.
  - start moves to RUN.
  - On that same edge, exp_idx, err_count, first_fail_* and seq_err are cleared.
- RUN (busy=1):
  - Each cycle with in_valid=1 is one sample.
  - ord_bad = (in_vec != exp_idx).
  - mask[i] = in_f[i] XOR EXP_TABLE[in_vec].
  - A sample fails if ord_bad=1 or mask != 0.
  - On a failing sample, err_count increments; it saturates at 16.
  - On the first failing sample only, first_fail_vec <= in_vec and first_fail_mask <= mask. If the sample failed only by ord_bad, first_fail_mask = 0.
  - ord_bad sets seq_err; seq_err stays set until the next start or reset.
  - exp_idx increments on every sample, whether it passed or failed. It does not resync to in_vec.
  - A sample with exp_idx=15 is the last one; on that edge the FSM moves to DONE.
  - Cycles with in_valid=0 are idle gaps of any length. There is no timeout.
  - start during RUN is ignored.
- DONE (done=1, busy=0):
  - pass = (err_count==0) and (seq_err==0). The value is registered and is valid from the first DONE cycle.
  - in_valid is ignored.
  - err_count, first_fail_* and seq_err hold.
  - start moves to RUN and clears everything as in IDLE. pass and done drop on that edge.
- Latency: all status registers reflect a sample one cycle after its in_valid edge. done rises on the cycle after the 16th sample.
- start and in_valid in the same cycle while in IDLE or DONE: start is taken and the sample is discarded.
- Reset mid-RUN: the sweep is abandoned and the FSM returns to IDLE with all outputs at 0.
- Widths: err_count is 5 bits so that 16 failures are representable. exp_idx is 4 bits and never wraps inside RUN because of the exit at 15.

Test Plan:
- EXP_TABLE=16'hA5C3, NUM_F=3; start; 16 in-order samples with in_f = {3{EXP_TABLE[k]}} -> done=1 the cycle after the 16th sample, pass=1, err_count=0, seq_err=0.
- As above, but F2 inverted at vector 6 and at vector 9 -> err_count=2, first_fail_vec=6, first_fail_mask=3'b010, pass=0.
- Vectors 0..14 correct, then the 16th sample has in_vec=4'b0111 with correct F for vector 7 -> seq_err=1, err_count=1, first_fail_vec=7, first_fail_mask=0, pass=0.
- All 16 samples with in_f inverted, random in_valid gaps of 0..5 cycles -> err_count=16 (saturation exercised), first_fail_vec=0, first_fail_mask=3'b111, done only after the 16th valid.
- rst asserted after 8 samples -> next cycle busy=0, done=0, err_count=0. A new start plus a clean sweep -> pass=1.
- In DONE, issue start together with in_valid, vec=0 -> RUN with counters cleared and that sample discarded; exp_idx=0 on the next sample.
